mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/sat_counter.sv | 31 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, grant identifiers and the tie-break helper used on a grant.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } grant_e;

  // On a tie the port that did not win the previous grant is served, so
  // neither port can starve the other.
  function automatic grant_e pick_grant(input logic   d_req,
                                        input logic   i_req,
                                        input grant_e last);
    if (d_req && i_req) begin
      return (last == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      return GRANT_D;
    end else begin
      return GRANT_I;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Free-running up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the count
//   inc_i  - increment enable for this cycle
//   cnt_o  - current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the data (MEM stage) port and the
// instruction-fetch port. One transaction at a time; the winner's request
// fields are latched on grant and driven on mem_* while busy.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   d_req_i/d_we_i/d_addr_i/d_wdata_i - data-port request
//   d_ready_o/d_rdata_o    - data completion pulse and read value
//   i_req_i/i_addr_i       - fetch request (read only)
//   i_ready_o/i_rdata_o    - fetch completion pulse and instruction
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - shared memory request
//   mem_ack_i/mem_rdata_i  - memory completion and read data
//   stall_o                - pipeline stall request
//   err_o                  - sticky ack-timeout flag
//   conflict_cnt_o         - saturating count of stall cycles
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ready_o,
  output logic [31:0] i_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] conflict_cnt_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_e       r_state;
  grant_e           r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [31:0]      r_wdata;

  logic             w_busy;
  logic             w_timeout;
  logic             w_done;
  logic [31:0]      w_rdata;
  grant_e           w_grant;

  assign w_busy    = (r_state != IDLE);
  // The counter holds the number of BUSY cycles already spent without an
  // ack; when it reaches the limit this cycle is the forced completion.
  // A real ack in the same cycle always takes priority over the abort.
  assign w_timeout = w_busy && !mem_ack_i && (r_cnt == CNT_W'(ACK_TIMEOUT));
  assign w_done    = w_busy && (mem_ack_i || w_timeout);
  assign w_rdata   = mem_ack_i ? mem_rdata_i : 32'd0;
  assign w_grant   = pick_grant(d_req_i, i_req_i, r_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= GRANT_I;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req_i || i_req_i) begin
            r_cnt  <= '0;
            r_last <= w_grant;
            if (w_grant == GRANT_D) begin
              r_state <= BUSY_D;
              r_addr  <= d_addr_i;
              r_we    <= d_we_i;
              r_wdata <= d_wdata_i;
            end else begin
              r_state <= BUSY_I;
              r_addr  <= i_addr_i;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        BUSY_D, BUSY_I: begin
          if (w_done) begin
            r_state <= IDLE;
            if (w_timeout) begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = w_busy;
  assign mem_we_o    = w_busy && r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  assign d_ready_o = w_done && (r_state == BUSY_D);
  assign i_ready_o = w_done && (r_state == BUSY_I);
  assign d_rdata_o = d_ready_o ? w_rdata : 32'd0;
  assign i_rdata_o = i_ready_o ? w_rdata : 32'd0;

  assign stall_o = (d_req_i && !d_ready_o) || (i_req_i && !i_ready_o);
  assign err_o   = r_err;

  sat_counter #(
    .WIDTH(32)
  ) u_conflict_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_o),
    .cnt_o (conflict_cnt_o)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus for mem_arbiter with a transaction-level reference model
// compared on every falling edge, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_ready_o;
  logic [31:0] d_rdata_o;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_ready_o;
  logic [31:0] i_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, err_o;
  logic [31:0] conflict_cnt_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ACK_TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .d_req_i        (d_req_i),
    .d_we_i         (d_we_i),
    .d_addr_i       (d_addr_i),
    .d_wdata_i      (d_wdata_i),
    .d_ready_o      (d_ready_o),
    .d_rdata_o      (d_rdata_o),
    .i_req_i        (i_req_i),
    .i_addr_i       (i_addr_i),
    .i_ready_o      (i_ready_o),
    .i_rdata_o      (i_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .stall_o        (stall_o),
    .err_o          (err_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one outstanding transaction) ----------
  logic        m_on = 1'b0;
  logic        m_busy, m_port, m_last, m_err, m_we;
  logic [31:0] m_addr, m_wdata, m_conf;
  int          m_age;
  logic        e_done, e_dr, e_ir, e_stall;
  logic [31:0] e_rd;
  logic        q_log[$];

  always @(negedge clk) begin
    if (m_on) begin
      e_done  = m_busy && (mem_ack_i || (m_age == TO));
      e_dr    = e_done && (m_port == 1'b0);
      e_ir    = e_done && (m_port == 1'b1);
      e_rd    = (e_done && mem_ack_i) ? mem_rdata_i : 32'd0;
      e_stall = (d_req_i && !e_dr) || (i_req_i && !e_ir);
      check("mem_req", 32'(mem_req_o), 32'(m_busy));
      check("mem_we", 32'(mem_we_o), 32'(m_busy && m_we));
      if (m_busy) begin
        check("mem_addr", mem_addr_o, m_addr);
        check("mem_wdata", mem_wdata_o, m_wdata);
      end
      check("d_ready", 32'(d_ready_o), 32'(e_dr));
      check("d_rdata", d_rdata_o, e_dr ? e_rd : 32'd0);
      check("i_ready", 32'(i_ready_o), 32'(e_ir));
      check("i_rdata", i_rdata_o, e_ir ? e_rd : 32'd0);
      check("stall", 32'(stall_o), 32'(e_stall));
      check("err", 32'(err_o), 32'(m_err));
      check("conflict_cnt", conflict_cnt_o, m_conf);
      if (d_ready_o) q_log.push_back(1'b0);
      if (i_ready_o) q_log.push_back(1'b1);
    end
    if (rst_i) begin
      m_on = 1'b1; m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_err = 1'b0;
      m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_conf = 32'd0; m_age = 0;
    end else if (m_on) begin
      if (e_stall && (m_conf != 32'hFFFF_FFFF)) m_conf = m_conf + 32'd1;
      if (m_busy) begin
        if (e_done) begin
          m_busy = 1'b0;
          if (!mem_ack_i) m_err = 1'b1;
        end else begin
          m_age++;
        end
      end else if (d_req_i || i_req_i) begin
        m_port = (d_req_i && i_req_i) ? !m_last : i_req_i;
        m_last = m_port;
        m_busy = 1'b1;
        m_age  = 0;
        if (m_port == 1'b0) begin
          m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
        end else begin
          m_addr = i_addr_i; m_we = 1'b0; m_wdata = 32'd0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    i_req_i = 1'b0; i_addr_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  int sc;

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_conflict", conflict_cnt_o, 32'd0);
    rst_i = 1'b0;
    step();

    // Single data write, memory acks in the first busy cycle.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h8; d_wdata_i = 32'h5;
    #2 check("wr_stall_req_cycle", 32'(stall_o), 32'd1);
    step();
    mem_ack_i = 1'b1;
    #2;
    check("wr_mem_we", 32'(mem_we_o), 32'd1);
    check("wr_mem_addr", mem_addr_o, 32'h8);
    check("wr_mem_wdata", mem_wdata_o, 32'h5);
    check("wr_d_ready", 32'(d_ready_o), 32'd1);
    check("wr_stall_ack_cycle", 32'(stall_o), 32'd0);
    step();
    idle_inputs();
    #2;
    check("wr_back_idle", 32'(mem_req_o), 32'd0);
    check("wr_conflict", conflict_cnt_o, 32'd1);
    step();

    // Fetch with three extra wait cycles before the ack.
    i_req_i = 1'b1; i_addr_i = 32'h4; mem_rdata_i = 32'h13;
    sc = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_ack_i = 1'b1;
      #2;
      sc += int'(stall_o);
      if (k == 1) check("fetch_addr", mem_addr_o, 32'h4);
      if (k == 3) check("fetch_no_early_ready", 32'(i_ready_o), 32'd0);
      if (k == 4) begin
        check("fetch_ready", 32'(i_ready_o), 32'd1);
        check("fetch_rdata", i_rdata_o, 32'h13);
      end
      step();
    end
    idle_inputs();
    check("fetch_stall_cycles", 32'(sc), 32'd4);
    step();

    // Both ports requesting continuously from reset, zero-wait memory.
    reset_dut();
    q_log.delete();
    d_req_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hAA; d_we_i = 1'b0;
    i_req_i = 1'b1; i_addr_i = 32'h200; mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    repeat (8) step();
    idle_inputs();
    #2;
    check("tie_conflict", conflict_cnt_o, 32'd8);
    check("tie_grants", 32'(q_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < q_log.size()) check("tie_order", 32'(q_log[k]), 32'(k % 2));
    end
    step();

    // Ack timeout on a data read.
    reset_dut();
    d_req_i = 1'b1; d_addr_i = 32'h40;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (k == 4) check("to_no_ready_yet", 32'(d_ready_o), 32'd0);
      if (k == 5) begin
        check("to_ready", 32'(d_ready_o), 32'd1);
        check("to_rdata", d_rdata_o, 32'd0);
      end
      step();
    end
    idle_inputs();
    #2;
    check("to_err_set", 32'(err_o), 32'd1);
    check("to_idle", 32'(mem_req_o), 32'd0);
    step();
    step();
    check("to_err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of a fetch, with a late ack afterwards.
    reset_dut();
    i_req_i = 1'b1; i_addr_i = 32'h80;
    step();
    step();
    #2 check("rst_mid_busy", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; i_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD;
    #2;
    check("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mid_no_ready", 32'(i_ready_o), 32'd0);
    check("rst_mid_err", 32'(err_o), 32'd0);
    check("rst_mid_conflict", conflict_cnt_o, 32'd0);
    step();
    #2 check("rst_mid_late_ack", 32'(i_ready_o), 32'd0);
    idle_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
